// File: rtl/int_seq_pkg.sv
// Shared definitions for the interrupt sequencer: state encoding, vector table defaults,
// condition-code width and the vector address helper.
package int_seq_pkg;

   localparam int          FLAGS_W           = 4;
   localparam logic [31:0] DEF_VECTOR_BASE   = 32'h0000_0010;
   localparam logic [31:0] DEF_VECTOR_STRIDE = 32'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_VECTOR = 3'd2,
      ST_ISR    = 3'd3,
      ST_CHAIN  = 3'd4,
      ST_RETURN = 3'd5
   } seq_state_t;

   // Wraps modulo 2^32 by construction of the 32-bit result.
   function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                            input logic [31:0] stride,
                                            input logic [1:0]  num);
      logic [31:0] r;
      r = base + ({30'd0, num} * stride);
      return r;
   endfunction

endpackage

// File: rtl/int_ctx_regs.sv
// Saved interrupt context (return PC and CC flags); captured once on interrupt entry.
// Single-cycle capture, no backpressure; clear drops the context after it has been restored.
module int_ctx_regs
   import int_seq_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               capture,
   input  logic               clear,
   input  logic [31:0]        pc_in,
   input  logic [FLAGS_W-1:0] flags_in,
   output logic [31:0]        saved_pc,
   output logic [FLAGS_W-1:0] saved_flags
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         saved_pc    <= '0;
         saved_flags <= '0;
      end else if (capture) begin
         saved_pc    <= pc_in;
         saved_flags <= flags_in;
      end
   end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer with drain, vectoring, tail-chaining and context restore.
// Outputs are registered one cycle after the deciding input; fetch is held via stall, no other backpressure.
module int_sequencer
   import int_seq_pkg::*;
#(
   parameter logic [31:0] VECTOR_BASE   = DEF_VECTOR_BASE,
   parameter logic [31:0] VECTOR_STRIDE = DEF_VECTOR_STRIDE,
   parameter int          CHAIN_WAIT    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               int_req,
   input  logic [1:0]         int_number,
   input  logic               int_pending,
   input  logic               instr_boundary,
   input  logic [31:0]        next_pc,
   input  logic [FLAGS_W-1:0] flags_in,
   input  logic               reti_exec,
   output logic               int_ack_attended,
   output logic               int_ack_complete,
   output logic               pc_load,
   output logic [31:0]        pc_target,
   output logic               flags_load,
   output logic [FLAGS_W-1:0] flags_out,
   output logic               stall,
   output logic               in_isr,
   output logic               err_orphan_reti
);

   localparam int             CW        = $clog2(CHAIN_WAIT + 1) + 1;
   localparam logic [CW-1:0]  CHAIN_LIM = CW'(CHAIN_WAIT);
   localparam logic [CW-1:0]  CHAIN_ONE = CW'(1);
   localparam logic [CW-1:0]  CHAIN_TWO = CW'(2);

   seq_state_t          state, state_nxt;
   logic [CW-1:0]       chain_cnt, chain_cnt_nxt;
   logic                ctx_capture;
   logic                ctx_clear;
   logic                orphan;
   logic                isr_done;
   logic [31:0]         saved_pc;
   logic [FLAGS_W-1:0]  saved_flags;

   int_ctx_regs u_ctx (
      .clk         (clk),
      .rst         (rst),
      .capture     (ctx_capture),
      .clear       (ctx_clear),
      .pc_in       (next_pc),
      .flags_in    (flags_in),
      .saved_pc    (saved_pc),
      .saved_flags (saved_flags)
   );

   assign orphan    = reti_exec && (state != ST_ISR);
   assign isr_done  = reti_exec && (state == ST_ISR);
   assign ctx_clear = (state == ST_RETURN);

   always_comb begin
      state_nxt     = state;
      chain_cnt_nxt = '0;
      ctx_capture   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (int_req) begin
               if (instr_boundary) begin
                  ctx_capture = 1'b1;
                  state_nxt   = ST_VECTOR;
               end else begin
                  state_nxt   = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (instr_boundary) begin
               ctx_capture = 1'b1;
               state_nxt   = ST_VECTOR;
            end
         end
         ST_VECTOR: state_nxt = ST_ISR;
         ST_ISR: begin
            if (reti_exec) begin
               if (int_pending) begin
                  state_nxt     = ST_CHAIN;
                  chain_cnt_nxt = CHAIN_ONE;
               end else begin
                  state_nxt     = ST_RETURN;
               end
            end
         end
         ST_CHAIN: begin
            // chain_cnt holds the 1-based cycle index inside CHAIN; the first cycle never accepts.
            if (int_req && (chain_cnt >= CHAIN_TWO)) begin
               state_nxt = ST_VECTOR;
            end else if (chain_cnt >= CHAIN_LIM) begin
               state_nxt = ST_RETURN;
            end else begin
               chain_cnt_nxt = chain_cnt + CHAIN_ONE;
            end
         end
         ST_RETURN: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         chain_cnt        <= '0;
         int_ack_attended <= 1'b0;
         int_ack_complete <= 1'b0;
         pc_load          <= 1'b0;
         pc_target        <= '0;
         flags_load       <= 1'b0;
         flags_out        <= '0;
         stall            <= 1'b0;
         in_isr           <= 1'b0;
         err_orphan_reti  <= 1'b0;
      end else begin
         state            <= state_nxt;
         chain_cnt        <= chain_cnt_nxt;
         int_ack_attended <= (state_nxt == ST_VECTOR);
         // The handler finishes exactly on its RETI, whether it chains or returns.
         int_ack_complete <= isr_done;
         pc_load          <= (state_nxt == ST_VECTOR) || (state_nxt == ST_RETURN);
         flags_load       <= (state_nxt == ST_RETURN);
         stall            <= (state_nxt == ST_DRAIN)  || (state_nxt == ST_VECTOR) ||
                             (state_nxt == ST_CHAIN)  || (state_nxt == ST_RETURN);
         in_isr           <= (state_nxt == ST_ISR);
         err_orphan_reti  <= err_orphan_reti || orphan;
         if (state_nxt == ST_VECTOR) begin
            pc_target <= vec_addr(VECTOR_BASE, VECTOR_STRIDE, int_number);
         end else if (state_nxt == ST_RETURN) begin
            pc_target <= saved_pc;
         end else begin
            pc_target <= '0;
         end
         flags_out <= (state_nxt == ST_RETURN) ? saved_flags : '0;
      end
   end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: stimulus queues expected redirect/ack events,
// a negedge monitor pops and compares them; state-level outputs are checked inline.
module tb_int_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        int_req;
   logic [1:0]  int_number;
   logic        int_pending;
   logic        instr_boundary;
   logic [31:0] next_pc;
   logic [3:0]  flags_in;
   logic        reti_exec;
   logic        int_ack_attended;
   logic        int_ack_complete;
   logic        pc_load;
   logic [31:0] pc_target;
   logic        flags_load;
   logic [3:0]  flags_out;
   logic        stall;
   logic        in_isr;
   logic        err_orphan_reti;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int          id;
      logic        pl;
      logic [31:0] tgt;
      logic        fl;
      logic [3:0]  fo;
      logic        aa;
      logic        ac;
   } ev_t;

   ev_t exp_q[$];

   int_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .int_req          (int_req),
      .int_number       (int_number),
      .int_pending      (int_pending),
      .instr_boundary   (instr_boundary),
      .next_pc          (next_pc),
      .flags_in         (flags_in),
      .reti_exec        (reti_exec),
      .int_ack_attended (int_ack_attended),
      .int_ack_complete (int_ack_complete),
      .pc_load          (pc_load),
      .pc_target        (pc_target),
      .flags_load       (flags_load),
      .flags_out        (flags_out),
      .stall            (stall),
      .in_isr           (in_isr),
      .err_orphan_reti  (err_orphan_reti)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic push_ev(input int id, input logic pl, input logic [31:0] tgt,
                          input logic fl, input logic [3:0] fo, input logic aa, input logic ac);
      ev_t e;
      e.id = id; e.pl = pl; e.tgt = tgt; e.fl = fl; e.fo = fo; e.aa = aa; e.ac = ac;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (pc_load || flags_load || int_ack_attended || int_ack_complete) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got pl=%0b tgt=%h fl=%0b fo=%b aa=%0b ac=%0b, expected no event",
                     pc_load, pc_target, flags_load, flags_out, int_ack_attended, int_ack_complete);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (pc_load !== e.pl || flags_load !== e.fl || int_ack_attended !== e.aa ||
                int_ack_complete !== e.ac || (e.pl && pc_target !== e.tgt) ||
                (e.fl && flags_out !== e.fo)) begin
               n_fail++;
               $display("FAIL event_%0d: got pl=%0b tgt=%h fl=%0b fo=%b aa=%0b ac=%0b, expected pl=%0b tgt=%h fl=%0b fo=%b aa=%0b ac=%0b",
                        e.id, pc_load, pc_target, flags_load, flags_out, int_ack_attended,
                        int_ack_complete, e.pl, e.tgt, e.fl, e.fo, e.aa, e.ac);
            end
         end
      end
   end

   // Enter an interrupt at an instruction boundary and expect the vector one cycle later.
   task automatic enter(input int id, input logic [1:0] num, input logic [31:0] pc,
                        input logic [3:0] fl, input logic [31:0] tgt);
      int_req = 1'b1; int_number = num; instr_boundary = 1'b1; next_pc = pc; flags_in = fl;
      push_ev(id, 1'b1, tgt, 1'b0, 4'h0, 1'b1, 1'b0);
      step();
      int_req = 1'b0; instr_boundary = 1'b0;
      int_number = ~num;
      next_pc = 32'hDEAD_0000; flags_in = ~fl;
   endtask

   initial begin
      rst = 1'b1; int_req = 1'b0; int_number = 2'd0; int_pending = 1'b0;
      instr_boundary = 1'b0; next_pc = '0; flags_in = '0; reti_exec = 1'b0;
      step(); step();
      check("reset_stall", stall, 0);
      check("reset_err", err_orphan_reti, 0);
      rst = 1'b0;
      step();
      check("idle_stall", stall, 0);
      check("idle_in_isr", in_isr, 0);

      // Boundary entry: number 2 vectors to 0x18, then plain return restores 0x100 / 1010.
      enter(1, 2'd2, 32'h100, 4'b1010, 32'h18);
      check("vector_stall", stall, 1);
      step();
      check("isr_in_isr", in_isr, 1);
      check("isr_stall", stall, 0);
      step();
      reti_exec = 1'b1; int_pending = 1'b0;
      push_ev(2, 1'b1, 32'h100, 1'b1, 4'b1010, 1'b0, 1'b1);
      step();
      reti_exec = 1'b0;
      check("return_stall", stall, 1);
      step();
      check("post_return_stall", stall, 0);
      check("post_return_err", err_orphan_reti, 0);

      // Drain: three non-boundary cycles hold fetch before vectoring number 1.
      int_req = 1'b1; int_number = 2'd1; instr_boundary = 1'b0;
      next_pc = 32'h200; flags_in = 4'b0101;
      for (int i = 0; i < 3; i++) begin
         step();
         check("drain_stall", stall, 1);
         check("drain_no_vector", pc_load, 0);
      end
      instr_boundary = 1'b1;
      push_ev(3, 1'b1, 32'h14, 1'b0, 4'h0, 1'b1, 1'b0);
      step();
      int_req = 1'b0; instr_boundary = 1'b0; next_pc = 32'hBAD; flags_in = 4'hF;
      step();
      reti_exec = 1'b1;
      push_ev(4, 1'b1, 32'h200, 1'b1, 4'b0101, 1'b0, 1'b1);
      step();
      reti_exec = 1'b0;
      step();

      // Tail chain: request held from CHAIN cycle 1, accepted only in cycle 2, context kept.
      enter(5, 2'd0, 32'h300, 4'b0011, 32'h10);
      step();
      reti_exec = 1'b1; int_pending = 1'b1;
      push_ev(6, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1);
      step();
      reti_exec = 1'b0; int_pending = 1'b0;
      check("chain1_stall", stall, 1);
      check("chain1_in_isr", in_isr, 0);
      int_req = 1'b1; int_number = 2'd3; next_pc = 32'h400; flags_in = 4'b1111;
      push_ev(7, 1'b1, 32'h1C, 1'b0, 4'h0, 1'b1, 1'b0);
      step();
      check("chain2_no_vector", pc_load, 0);
      check("chain2_stall", stall, 1);
      step();
      int_req = 1'b0; int_number = 2'd0;
      step();
      check("chained_isr", in_isr, 1);
      reti_exec = 1'b1;
      push_ev(8, 1'b1, 32'h300, 1'b1, 4'b0011, 1'b0, 1'b1);
      step();
      reti_exec = 1'b0;
      step();

      // Chain timeout: no request for two CHAIN cycles, RETURN without a second completion.
      enter(9, 2'd1, 32'h500, 4'b1100, 32'h14);
      step();
      reti_exec = 1'b1; int_pending = 1'b1;
      push_ev(10, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1);
      step();
      reti_exec = 1'b0; int_pending = 1'b0;
      push_ev(11, 1'b1, 32'h500, 1'b1, 4'b1100, 1'b0, 1'b0);
      step();
      check("timeout_chain2_stall", stall, 1);
      step();
      check("timeout_return_stall", stall, 1);
      step();
      check("timeout_idle_stall", stall, 0);

      // Orphan RETI in IDLE is sticky; reset in DRAIN clears it and returns to IDLE.
      reti_exec = 1'b1;
      step();
      reti_exec = 1'b0;
      check("orphan_set", err_orphan_reti, 1);
      check("orphan_no_redirect", pc_load, 0);
      step();
      check("orphan_sticky", err_orphan_reti, 1);
      int_req = 1'b1; instr_boundary = 1'b0;
      step();
      check("drain_before_rst", stall, 1);
      rst = 1'b1; int_req = 1'b0;
      step();
      check("rst_stall", stall, 0);
      check("rst_err", err_orphan_reti, 0);
      rst = 1'b0;
      step();
      check("after_rst_stall", stall, 0);
      check("after_rst_in_isr", in_isr, 0);

      enter(12, 2'd3, 32'h600, 4'b0110, 32'h1C);
      step();
      reti_exec = 1'b1;
      push_ev(13, 1'b1, 32'h600, 1'b1, 4'b0110, 1'b0, 1'b1);
      step();
      reti_exec = 1'b0;
      step(); step(); step();
      check("events_outstanding", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
